// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronises and deglitches raw SCL/SDA, decodes
// START/STOP from the filtered levels, tracks bus-busy and flags lines
// held low beyond a timeout. Line index 0 is SCL, 1 is SDA.
module i2c_line_filter #(
  parameter int unsigned     FILT_LEN = 4,
  parameter int unsigned     TO_W     = 20,
  parameter logic [TO_W-1:0] TIMEOUT  = 20'd500000
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_out,
  output logic sda_out,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic scl_stuck,
  output logic sda_stuck
);

  localparam int unsigned NUM_LINES = 2;
  localparam int unsigned CW        = $clog2(FILT_LEN + 1);

  logic [NUM_LINES-1:0] w_raw;
  logic [NUM_LINES-1:0] w_filt;
  logic [NUM_LINES-1:0] w_stuck;

  assign w_raw = {sda_in, scl_in};

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    logic            r_s1, r_s2, r_out, r_stuck;
    logic [CW-1:0]   r_fcnt;
    logic [TO_W-1:0] r_tcnt;
    logic            w_out_nxt;
    logic [CW-1:0]   w_fcnt_nxt;
    logic [TO_W-1:0] w_tcnt_nxt;

    // Glitch filter next state: follow s2 only after FILT_LEN straight disagreeing samples.
    always_comb begin
      w_out_nxt  = r_out;
      w_fcnt_nxt = '0;
      if (r_s2 != r_out) begin
        if (r_fcnt + CW'(1) == CW'(FILT_LEN)) w_out_nxt  = r_s2;
        else                                   w_fcnt_nxt = r_fcnt + CW'(1);
      end
    end

    // Stuck counter tracks the next filtered level so the lowering edge counts as 1.
    always_comb begin
      w_tcnt_nxt = '0;
      if (!w_out_nxt)
        w_tcnt_nxt = (r_tcnt == TIMEOUT) ? r_tcnt : r_tcnt + TO_W'(1);
    end

    // Per-line synchroniser, filter and stuck state.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1    <= 1'b1;
        r_s2    <= 1'b1;
        r_out   <= 1'b1;
        r_fcnt  <= '0;
        r_tcnt  <= '0;
        r_stuck <= 1'b0;
      end else begin
        r_s1    <= w_raw[g];
        r_s2    <= r_s1;
        r_out   <= w_out_nxt;
        r_fcnt  <= w_fcnt_nxt;
        r_tcnt  <= w_tcnt_nxt;
        r_stuck <= (w_tcnt_nxt == TIMEOUT);
      end
    end

    assign w_filt[g]  = r_out;
    assign w_stuck[g] = r_stuck;
  end

  logic r_scl_d, r_sda_d, r_start, r_stop, r_busy;
  logic w_start_cond, w_stop_cond;

  // SCL must be high in both the previous and current cycle, so a
  // simultaneous SCL/SDA change never decodes as a condition.
  assign w_start_cond = r_sda_d & ~w_filt[1] & r_scl_d & w_filt[0];
  assign w_stop_cond  = ~r_sda_d & w_filt[1] & r_scl_d & w_filt[0];

  // Condition decoder: registered pulses and bus-busy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_scl_d <= w_filt[0];
      r_sda_d <= w_filt[1];
      r_start <= w_start_cond;
      r_stop  <= w_stop_cond;
      if (w_start_cond)     r_busy <= 1'b1;
      else if (w_stop_cond) r_busy <= 1'b0;
    end
  end

  assign scl_out   = w_filt[0];
  assign sda_out   = w_filt[1];
  assign start_det = r_start;
  assign stop_det  = r_stop;
  assign bus_busy  = r_busy;
  assign scl_stuck = w_stuck[0];
  assign sda_stuck = w_stuck[1];

endmodule
